// File: rtl/bin_div_pkg.sv
// Shared definitions for the restoring binary divider: FSM state encoding
// and the default operand widths.
package bin_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DVD_W_DEF = 10;
    localparam int DVS_W_DEF = 5;

endpackage

// File: rtl/bin_divider_div_step.sv
// One restoring-division step: trial-subtract the divisor from the already
// shifted partial remainder and keep the difference only if it did not go
// negative. Purely combinational.
module div_step
    import bin_div_pkg::*;
#(
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic [DVS_W:0]   part_rem,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVS_W:0]   next_rem,
    output logic             q_bit
);

    logic [DVS_W:0] dvs_ext;
    logic [DVS_W:0] diff;

    assign dvs_ext = {1'b0, divisor};
    assign diff    = part_rem - dvs_ext;

    // Restore (keep the old value) when the trial subtraction would underflow.
    always_comb begin
        q_bit    = 1'b0;
        next_rem = part_rem;
        if (part_rem >= dvs_ext) begin
            q_bit    = 1'b1;
            next_rem = diff;
        end
    end

endmodule

// File: rtl/bin_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// The dividend shift register doubles as the quotient register: each step
// shifts a dividend bit out of the top and the new quotient bit into the LSB.
// The done pulse is registered from the DONE state, so it appears one cycle
// after the results are written; a load arriving in that cycle is ignored.
module bin_divider
    import bin_div_pkg::*;
#(
    parameter int DVD_W = DVD_W_DEF,
    parameter int DVS_W = DVS_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(DVD_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DVD_W - 1);

    div_state_t       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [DVS_W:0]   rem_reg;
    logic [DVD_W-1:0] dvd_reg;
    logic [DVS_W-1:0] dvs_reg;
    logic [DVD_W-1:0] quotient_reg;
    logic [DVS_W-1:0] remainder_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             dbz_reg;

    logic [DVS_W+DVD_W:0] work_shl;
    logic [DVS_W:0]       rem_next;
    logic [DVD_W-1:0]     dvd_next;
    logic                 q_bit;

    // {partial remainder, dividend} shifted left by one; the top slice is the
    // trial value for this step, the bottom slice the shifted dividend/quotient.
    assign work_shl = {rem_reg, dvd_reg} << 1;
    assign dvd_next = work_shl[DVD_W-1:0] | DVD_W'(q_bit);

    div_step #(
        .DVS_W(DVS_W)
    ) u_step (
        .part_rem(work_shl[DVS_W+DVD_W:DVD_W]),
        .divisor (dvs_reg),
        .next_rem(rem_next),
        .q_bit   (q_bit)
    );

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            dvd_reg       <= '0;
            dvs_reg       <= '0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            dbz_reg       <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            case (state_reg)
                IDLE: begin
                    if (load && !done_reg) begin
                        dvd_reg  <= dividend;
                        dvs_reg  <= divisor;
                        rem_reg  <= '0;
                        cnt_reg  <= '0;
                        busy_reg <= 1'b1;
                        dbz_reg  <= (divisor == '0);
                        if (divisor == '0) begin
                            quotient_reg  <= '1;
                            remainder_reg <= '0;
                            state_reg     <= DONE;
                        end else begin
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_reg <= rem_next;
                    dvd_reg <= dvd_next;
                    cnt_reg <= cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_LAST) begin
                        quotient_reg  <= dvd_next;
                        remainder_reg <= rem_next[DVS_W-1:0];
                        state_reg     <= DONE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_bin_divider.sv
// Directed and randomised checks for bin_divider with default widths.
module tb_bin_divider;

    logic       clk;
    logic       reset;
    logic       load;
    logic [9:0] dividend;
    logic [4:0] divisor;
    logic [9:0] quotient;
    logic [4:0] remainder;
    logic       busy;
    logic       done;
    logic       div_by_zero;

    int checks;
    int failures;

    bin_divider dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Issue a one-cycle load; returns #1 after the accepting edge.
    task automatic start_op(input logic [9:0] a, input logic [4:0] b);
        if (done) begin
            @(posedge clk);
            #1;
        end
        dividend = a;
        divisor  = b;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Count edges after the accepting edge until done is seen (bounded).
    task automatic wait_done(input int already, output int lat);
        lat = already;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) check("timeout_done", 32'd0, 32'd1);
    endtask

    task automatic directed(input string tag, input logic [9:0] a, input logic [4:0] b,
                            input int exp_lat, input logic [9:0] eq, input logic [4:0] er,
                            input logic edbz);
        int lat;
        start_op(a, b);
        check({tag, "_busy"}, busy, 1'b1);
        wait_done(0, lat);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, div_by_zero, edbz);
        $display("op %s: %0d/%0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b, quotient, remainder, div_by_zero, lat);
    endtask

    initial begin
        int lat;
        int seen;
        logic [9:0] ra;
        logic [4:0] rb;
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        load     = 1'b0;
        dividend = '0;
        divisor  = '0;

        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        directed("d100_7", 10'd100, 5'd7, 11, 10'd14, 5'd2, 1'b0);
        directed("d1023_31", 10'd1023, 5'd31, 11, 10'd33, 5'd0, 1'b0);

        // A load presented in the done cycle must be ignored.
        dividend = 10'd5;
        divisor  = 5'd9;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        check("load_in_done_busy", busy, 0);
        check("load_in_done_q", quotient, 33);
        $display("op load_in_done: busy=%0d q=%0d", busy, quotient);

        directed("d5_9", 10'd5, 5'd9, 11, 10'd0, 5'd5, 1'b0);
        directed("d200_0", 10'd200, 5'd0, 1, 10'h3FF, 5'd0, 1'b1);
        @(posedge clk);
        #1;
        check("dbz_hold", div_by_zero, 1);
        check("dbz_hold_done", done, 0);
        directed("d6_3", 10'd6, 5'd3, 11, 10'd2, 5'd0, 1'b0);

        // Second load during CALC has no effect.
        start_op(10'd100, 5'd7);
        repeat (2) @(posedge clk);
        #1;
        dividend = 10'd50;
        divisor  = 5'd5;
        load     = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        wait_done(3, lat);
        check("midload_lat", lat, 11);
        check("midload_q", quotient, 14);
        check("midload_r", remainder, 2);
        $display("op midload: q=%0d r=%0d lat=%0d", quotient, remainder, lat);

        // Reset in the 4th CALC cycle aborts with no done pulse.
        @(posedge clk);
        #1;
        start_op(10'd100, 5'd7);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_q", quotient, 0);
        check("abort_r", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", div_by_zero, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen  = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen = 1;
        end
        check("abort_no_done", seen, 0);
        $display("op abort: seen_activity=%0d", seen);
        directed("d9_2", 10'd9, 5'd2, 11, 10'd4, 5'd1, 1'b0);

        // Random sweep, back-to-back loads on the first free cycle.
        for (int i = 0; i < 2000; i++) begin
            ra = 10'($urandom_range(0, 1023));
            rb = 5'($urandom_range(1, 31));
            start_op(ra, rb);
            wait_done(0, lat);
            check("rnd_q", quotient, 32'(ra) / 32'(rb));
            check("rnd_r", remainder, 32'(ra) % 32'(rb));
            if (i % 200 == 0)
                $display("op rnd%0d: %0d/%0d -> q=%0d r=%0d", i, ra, rb, quotient, remainder);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
